// File: rtl/t5_pkg.sv
// Shared definitions for the t5 data-memory initiator.
// Provides access-size codes, FSM state encoding and the default abort limit.
package t5_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int TMO_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/t5_dmem_lane.sv
// Byte-lane steering for data accesses: lane select, replicated store data
// and misalignment flag from size, address offset and rs2 data (all comb).
module t5_dmem_lane
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] dat,
  output logic [3:0]      sel,
  output logic [XLEN-1:0] dto,
  output logic            mis
);

  always_comb begin
    sel = 4'h0;
    dto = dat;
    mis = 1'b0;
    case (size)
      SZ_B: begin
        sel = 4'b0001 << off;
        dto = {4{dat[7:0]}};
      end
      SZ_H: begin
        sel = off[1] ? 4'hC : 4'h3;
        dto = {2{dat[15:0]}};
        mis = off[0];
      end
      SZ_W: begin
        sel = 4'hF;
        dto = dat;
        mis = |off;
      end
      // size 11 has no legal access
      default: mis = 1'b1;
    endcase
  end

endmodule

// File: rtl/t5_dmem.sv
// Wishbone data-port initiator driven by the X stage: issues classic
// load/store cycles, stalls the pipeline until ack or timeout abort.
// Ports: sclk/srst, X-stage request (xld/xst/xfn3/xadr/xdat/xhart/sena),
// Wishbone master (dwb_*), xsel/dhart to load-extension, dstall/dmis/derr.
module t5_dmem
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TMO  = TMO_DEF
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            xld,
  input  logic            xst,
  input  logic [2:0]      xfn3,
  input  logic [XLEN-1:0] xadr,
  input  logic [XLEN-1:0] xdat,
  input  logic [1:0]      xhart,
  output logic [XLEN-3:0] dwb_adr,
  output logic [XLEN-1:0] dwb_dto,
  output logic [3:0]      dwb_sel,
  output logic            dwb_stb,
  output logic            dwb_cyc,
  output logic            dwb_wre,
  input  logic            dwb_ack,
  output logic [3:0]      xsel,
  output logic [1:0]      dhart,
  output logic            dstall,
  output logic            dmis,
  output logic            derr
);

  localparam int CW = $clog2(TMO) + 1;
  localparam logic [CW-1:0] CLAST = CW'(TMO - 1);

  state_t          st;
  logic [CW-1:0]   cnt;
  logic            done;
  logic [3:0]      sel;
  logic [XLEN-1:0] dto;
  logic            mis;
  logic            xreq;
  logic            launch;
  logic            busy;
  logic            last;
  logic            unused;

  assign unused = xfn3[2];

  t5_dmem_lane #(
    .XLEN(XLEN)
  ) u_lane (
    .size(xfn3[1:0]),
    .off (xadr[1:0]),
    .dat (xdat),
    .sel (sel),
    .dto (dto),
    .mis (mis)
  );

  assign xreq   = (xld | xst) & ~mis;
  assign busy   = (st == ST_BUSY);
  assign last   = (cnt == CLAST);
  // done keeps a completed-but-not-advanced instruction from reissuing
  assign launch = (st == ST_IDLE) & xreq & ~done;
  assign dstall = launch | (busy & ~dwb_ack & ~last);
  assign dmis   = (xld | xst) & mis;

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      derr    <= 1'b0;
      dwb_stb <= 1'b0;
      dwb_cyc <= 1'b0;
      dwb_wre <= 1'b0;
      dwb_adr <= '0;
      dwb_dto <= '0;
      dwb_sel <= 4'h0;
      xsel    <= 4'h0;
      dhart   <= 2'b00;
    end else begin
      derr <= 1'b0;
      if (sena) done <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (launch) begin
            st      <= ST_BUSY;
            cnt     <= '0;
            dwb_stb <= 1'b1;
            dwb_cyc <= 1'b1;
            dwb_wre <= xst;
            dwb_adr <= xadr[XLEN-1:2];
            dwb_dto <= dto;
            dwb_sel <= sel;
            xsel    <= sel;
            dhart   <= xhart;
          end
        end
        ST_BUSY: begin
          if (dwb_ack || last) begin
            st      <= ST_IDLE;
            dwb_stb <= 1'b0;
            dwb_cyc <= 1'b0;
            // ack beats a coincident timeout
            derr    <= ~dwb_ack;
            done    <= ~sena;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t5_dmem.sv
// Directed bench for t5_dmem with a registered-ack Wishbone target model
// and a scoreboard queue of expected bus transactions.
module tb_t5_dmem;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] dto;
    logic [3:0]  sel;
    logic        wre;
    logic [1:0]  hart;
  } txn_t;

  logic        sclk = 1'b0;
  logic        srst;
  logic        sena;
  logic        xld;
  logic        xst;
  logic [2:0]  xfn3;
  logic [31:0] xadr;
  logic [31:0] xdat;
  logic [1:0]  xhart;
  logic [29:0] dwb_adr;
  logic [31:0] dwb_dto;
  logic [3:0]  dwb_sel;
  logic        dwb_stb;
  logic        dwb_cyc;
  logic        dwb_wre;
  logic        dwb_ack;
  logic [3:0]  xsel;
  logic [1:0]  dhart;
  logic        dstall;
  logic        dmis;
  logic        derr;

  int   total = 0;
  int   bad = 0;
  txn_t q[$];

  logic ack_en;
  logic ack_force;
  logic ack_r;
  int   waits;
  int   wc;

  always #5 sclk = ~sclk;

  t5_dmem dut (
    .sclk   (sclk),
    .srst   (srst),
    .sena   (sena),
    .xld    (xld),
    .xst    (xst),
    .xfn3   (xfn3),
    .xadr   (xadr),
    .xdat   (xdat),
    .xhart  (xhart),
    .dwb_adr(dwb_adr),
    .dwb_dto(dwb_dto),
    .dwb_sel(dwb_sel),
    .dwb_stb(dwb_stb),
    .dwb_cyc(dwb_cyc),
    .dwb_wre(dwb_wre),
    .dwb_ack(dwb_ack),
    .xsel   (xsel),
    .dhart  (dhart),
    .dstall (dstall),
    .dmis   (dmis),
    .derr   (derr)
  );

  // target: sees stb, waits 'waits' extra cycles, acks one cycle (registered)
  assign dwb_ack = ack_r | ack_force;

  always @(posedge sclk or posedge srst) begin
    if (srst) begin
      ack_r <= 1'b0;
      wc    <= 0;
    end else if (ack_en && dwb_stb && !ack_r) begin
      if (wc >= waits) begin
        ack_r <= 1'b1;
        wc    <= 0;
      end else begin
        wc <= wc + 1;
      end
    end else begin
      ack_r <= 1'b0;
      if (!dwb_stb) wc <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st,
                       input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] h,
                       input int w, input int exp_stall, input int exp_stb,
                       input txn_t e);
    txn_t t;
    int   ns;
    int   nb;
    bit   got;
    bit   ended;
    q.push_back(e);
    @(negedge sclk);
    waits = w;
    xld   = ld;
    xst   = st;
    xfn3  = fn;
    xadr  = a;
    xdat  = d;
    xhart = h;
    #1;
    ns    = 0;
    nb    = 0;
    got   = 0;
    ended = 0;
    for (int i = 0; i < 64; i++) begin
      if (dwb_stb) nb++;
      if (dwb_stb && !got && q.size() > 0) begin
        t = q.pop_front();
        got = 1;
        chk("adr", 64'(dwb_adr), 64'(t.adr));
        chk("dto", 64'(dwb_dto), 64'(t.dto));
        chk("sel", 64'(dwb_sel), 64'(t.sel));
        chk("wre", 64'(dwb_wre), 64'(t.wre));
        chk("xsel", 64'(xsel), 64'(t.sel));
        chk("dhart", 64'(dhart), 64'(t.hart));
        chk("cyc", 64'(dwb_cyc), 64'(1));
      end
      if (!dstall) begin
        ended = 1;
        break;
      end
      ns++;
      @(negedge sclk);
      #1;
    end
    chk("bound", 64'(ended), 64'(1));
    chk("issued", 64'(got), 64'(1));
    chk("stall_cycles", 64'(ns), 64'(exp_stall));
    chk("stb_cycles", 64'(nb), 64'(exp_stb));
  endtask

  task automatic retire(input logic exp_derr);
    @(negedge sclk);
    xld = 1'b0;
    xst = 1'b0;
    #1;
    chk("stb_after", 64'(dwb_stb), 64'(0));
    chk("cyc_after", 64'(dwb_cyc), 64'(0));
    chk("derr_after", 64'(derr), 64'(exp_derr));
    chk("dstall_after", 64'(dstall), 64'(0));
  endtask

  initial begin
    srst      = 1'b1;
    sena      = 1'b1;
    xld       = 1'b0;
    xst       = 1'b0;
    xfn3      = 3'b000;
    xadr      = 32'h0;
    xdat      = 32'h0;
    xhart     = 2'b00;
    ack_en    = 1'b1;
    ack_force = 1'b0;
    waits     = 0;

    repeat (2) @(negedge sclk);
    #1;
    chk("rst_stb", 64'(dwb_stb), 64'(0));
    chk("rst_cyc", 64'(dwb_cyc), 64'(0));
    chk("rst_wre", 64'(dwb_wre), 64'(0));
    chk("rst_derr", 64'(derr), 64'(0));
    chk("rst_adr", 64'(dwb_adr), 64'(0));
    chk("rst_dto", 64'(dwb_dto), 64'(0));
    chk("rst_sel", 64'(dwb_sel), 64'(0));
    chk("rst_xsel", 64'(xsel), 64'(0));
    chk("rst_dhart", 64'(dhart), 64'(0));
    chk("rst_dstall", 64'(dstall), 64'(0));
    srst = 1'b0;

    // store byte, zero-wait target
    issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 2'd1, 0, 2, 2,
          '{adr: 30'h400, dto: 32'hA5A5_A5A5, sel: 4'h8, wre: 1'b1,
            hart: 2'd1});
    retire(1'b0);

    // load half upper, three wait states
    issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h1234_5678, 2'd2, 3, 5, 5,
          '{adr: 30'h800, dto: 32'h5678_5678, sel: 4'hC, wre: 1'b0,
            hart: 2'd2});
    retire(1'b0);
    repeat (3) @(negedge sclk);
    #1;
    chk("xsel_hold", 64'(xsel), 64'(4'hC));
    chk("dhart_hold", 64'(dhart), 64'(2'd2));

    // misaligned accesses never reach the bus
    @(negedge sclk);
    xld  = 1'b1;
    xfn3 = 3'b010;
    xadr = 32'h0000_3001;
    #1;
    chk("mis_w", 64'(dmis), 64'(1));
    chk("mis_w_stall", 64'(dstall), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      #1;
      chk("mis_w_stb", 64'(dwb_stb), 64'(0));
    end
    xfn3 = 3'b001;
    xadr = 32'h0000_2001;
    #1;
    chk("mis_h", 64'(dmis), 64'(1));
    xfn3 = 3'b011;
    xadr = 32'h0000_2000;
    #1;
    chk("mis_sz3", 64'(dmis), 64'(1));
    xld = 1'b0;
    #1;
    chk("mis_noreq", 64'(dmis), 64'(0));
    @(negedge sclk);
    #1;
    chk("mis_stb_end", 64'(dwb_stb), 64'(0));

    // no ack: abort after TMO bus cycles
    ack_en = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 2'd3, 0, 16, 16,
          '{adr: 30'h1000, dto: 32'hDEAD_BEEF, sel: 4'hF, wre: 1'b0,
            hart: 2'd3});
    retire(1'b1);
    @(negedge sclk);
    #1;
    chk("derr_pulse", 64'(derr), 64'(0));
    ack_en = 1'b1;

    // ack while pipeline held: no relaunch of the same instruction
    sena = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 2'd0, 0, 2, 2,
          '{adr: 30'h1400, dto: 32'h0, sel: 4'hF, wre: 1'b0, hart: 2'd0});
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      #1;
      chk("held_stb", 64'(dwb_stb), 64'(0));
      chk("held_stall", 64'(dstall), 64'(0));
    end
    @(negedge sclk);
    sena = 1'b1;
    #1;
    chk("adv_stall", 64'(dstall), 64'(0));
    @(negedge sclk);
    xld = 1'b0;
    #1;
    chk("adv_stb", 64'(dwb_stb), 64'(0));

    // stray ack in IDLE
    @(negedge sclk);
    ack_force = 1'b1;
    @(negedge sclk);
    ack_force = 1'b0;
    #1;
    chk("idle_ack_stb", 64'(dwb_stb), 64'(0));
    chk("idle_ack_derr", 64'(derr), 64'(0));

    // store word with one wait, store byte at lane 1
    issue(1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 2'd1, 1, 3, 3,
          '{adr: 30'h1800, dto: 32'hCAFE_F00D, sel: 4'hF, wre: 1'b1,
            hart: 2'd1});
    retire(1'b0);
    issue(1'b0, 1'b1, 3'b000, 32'h0000_7001, 32'h0000_003C, 2'd0, 0, 2, 2,
          '{adr: 30'h1C00, dto: 32'h3C3C_3C3C, sel: 4'h2, wre: 1'b1,
            hart: 2'd0});
    retire(1'b0);

    // reset in the middle of a bus cycle
    @(negedge sclk);
    waits = 8;
    xst   = 1'b1;
    xfn3  = 3'b010;
    xadr  = 32'h0000_8000;
    xdat  = 32'h1122_3344;
    xhart = 2'd2;
    repeat (2) @(negedge sclk);
    #1;
    chk("pre_rst_stb", 64'(dwb_stb), 64'(1));
    srst = 1'b1;
    xst  = 1'b0;
    #1;
    chk("mid_rst_stb", 64'(dwb_stb), 64'(0));
    chk("mid_rst_cyc", 64'(dwb_cyc), 64'(0));
    chk("mid_rst_stall", 64'(dstall), 64'(0));
    chk("mid_rst_derr", 64'(derr), 64'(0));
    @(negedge sclk);
    srst = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_9000, 32'h5566_7788, 2'd3, 0, 2, 2,
          '{adr: 30'h2400, dto: 32'h5566_7788, sel: 4'hF, wre: 1'b1,
            hart: 2'd3});
    retire(1'b0);

    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t5_dmem.md
Name: t5_dmem

Overview:
- Data-bus initiator of the t5 core on the Wishbone data port, driven by the X stage.
- Issues load and store cycles with byte-lane steering and store-data replication.
- Exports the byte-select the writeback/load-extension stage consumes with dwb_dti.
- Stalls the pipeline until dwb_ack arrives or the cycle times out.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TMO, 16, max BUSY cycles before abort (>=2)

Ports:
sclk  in  1  core clock
srst  in  1  reset, asynchronous, active-high
sena  in  1  pipeline advance enable
xld  in  1  X-stage instruction is a load
xst  in  1  X-stage instruction is a store
xfn3  in  3  [14:12] funct3; [13:12] size (00 byte, 01 half, 10 word)
xadr  in  XLEN  effective address from ALU
xdat  in  XLEN  rs2 store data
xhart  in  2  hart id of X-stage instruction
dwb_adr  out  XLEN-2  word address [XLEN-1:2]
dwb_dto  out  XLEN  store data, lane-replicated
dwb_sel  out  4  byte lanes
dwb_stb  out  1  strobe
dwb_cyc  out  1  cycle
dwb_wre  out  1  1=write
dwb_ack  in  1  target acknowledge
xsel  out  4  lanes of last issued access, to load-extension stage
dhart  out  2  hart tag of last issued access
dstall  out  1  hold pipeline (comb)
dmis  out  1  misaligned access (comb)
derr  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async): state IDLE; dwb_stb, dwb_cyc, dwb_wre, derr, done = 0; dwb_adr, dwb_dto, dwb_sel, xsel, dhart = 0; timeout counter = 0.
- Lane rules. Byte: sel = 1<<xadr[1:0], dto = {4{xdat[7:0]}}.
- Half: sel = xadr[1] ? 4'hC : 4'h3, dto = {2{xdat[15:0]}}; misaligned if xadr[0].
- Word: sel = 4'hF, dto = xdat; misaligned if xadr[1:0] != 0.
- Size 11: treated as misaligned.
- dmis = (xld|xst) & misaligned. No bus cycle, no stall; trap handling is external.
- xreq = (xld|xst) & !misaligned; launch = IDLE & xreq & !done.
- IDLE -> BUSY on launch. On that edge register dwb_adr, dwb_dto, dwb_sel, dwb_wre = xst, xsel = sel, dhart = xhart; set stb = cyc = 1; clear counter.
- BUSY, dwb_ack = 1: drop stb/cyc at the next edge and go to IDLE.
  - If sena = 0 that cycle, set done, which blocks relaunch of the same instruction.
  - done clears on any cycle with sena = 1.
- BUSY, no ack: increment counter. At counter == TMO-1 with no ack: abort, drop stb/cyc, pulse derr, go to IDLE; done is set/cleared as on ack.
- ack and timeout in the same cycle: ack wins, no derr.
- dstall = launch | (BUSY & !dwb_ack & !(counter == TMO-1)).
  - Store latency: issue cycle + 1 bus cycle minimum, so a zero-wait target stalls 2 cycles.
- xsel/dhart stay stable from launch until the next launch; the load-extension stage samples dwb_dti with xsel in the ack cycle.
- dwb_ack in IDLE is ignored.
- stb, adr, dto, sel and wre stay constant through BUSY (classic cycle).
- Output is registered, so no combinational path from dwb_ack to dwb_stb. dwb_ack does reach dstall combinationally.
- Reset mid-cycle: bus signals drop immediately; no derr.

Decomposition:
- Shared package t5_pkg: size encodings (SZ_B, SZ_H, SZ_W), state encoding (ST_IDLE, ST_BUSY), TMO default.
- One sub-module, t5_dmem_lane: combinational sel/dto/misaligned generation from xfn3[13:12], xadr[1:0], xdat.
- The FSM, counter and registers stay in t5_dmem.

Test Plan:
- Store byte, xadr = 0x1003, xdat = 0xA5 -> dwb_adr = 0x400, sel = 8, dto = A5A5A5A5, wre = 1; ack after 0 wait -> dstall high 2 cycles, stb low afterwards.
- Load half, xadr = 0x2002, ack after 3 waits -> xsel = C, dstall high 5 cycles, dhart = xhart, wre = 0.
- Load word, xadr = 0x3001 -> dmis = 1, dstall = 0, stb never asserted.
- No ack with TMO = 16 -> stb high 16 cycles, derr pulses once, dstall drops, state returns to IDLE.
- ack while sena = 0, instruction still present 3 more cycles -> no second stb until sena = 1 and a new request arrives.
- srst asserted mid-BUSY -> stb/cyc/dstall drop asynchronously, derr = 0; after release a new store issues normally.
